sram_like_bridge: RTL and testbench
===================================

Name: sram_like_bridge

Overview:
- Parametrised bridge between a pipeline-stage request/response handshake (IF or EXE/MEM side) and the split-transaction SRAM-like bus (req/addr_ok/data_ok).
- Next-generation replacement for the single-cycle inst/data SRAM ports; supports multiple outstanding in-order requests, response buffering under back-pressure, and a cancel (flush) that discards stale responses.
- One instance per bus: instruction and data.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; must be a multiple of 8
MAX_OUT, 2, maximum requests issued or buffered and not yet consumed; >=1

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
cancel  in  1  flush pulse from branch/exception logic
cpu_req_valid  in  1  stage request valid
cpu_req_ready  out  1  bridge accepts request this cycle
cpu_req_wr  in  1  1=write
cpu_req_size  in  2  0=byte, 1=half, 2=word
cpu_req_wstrb  in  DATA_W/8  byte write enables
cpu_req_addr  in  ADDR_W  address
cpu_req_wdata  in  DATA_W  write data
cpu_resp_valid  out  1  response available
cpu_resp_ready  in  1  stage consumes response
cpu_resp_rdata  out  DATA_W  read data (undefined for writes)
req  out  1  bus request
wr  out  1  bus write
size  out  2  bus size
wstrb  out  DATA_W/8  bus byte strobes
addr  out  ADDR_W  bus address
wdata  out  DATA_W  bus write data
addr_ok  in  1  bus accepted address this cycle
data_ok  in  1  bus returns data/ack this cycle (in order)
rdata  in  DATA_W  bus read data

Behaviour:
- Reset: clk and resetn are the single clock and its asynchronous, active-low reset. When resetn is low, all state clears: pend=0, out_cnt=0, fifo_cnt=0, discard_cnt=0, req=0, cpu_resp_valid=0, cpu_req_ready=1. wr/size/wstrb/addr/wdata and cpu_resp_rdata reset to 0. Asserting resetn low mid-transaction abandons everything. The bus must be reset alongside.
- Request register: one entry, `pend` plus the captured fields.
  - cpu_req_ready = !cancel && (!pend || (req && addr_ok)). This is combinational on addr_ok.
  - Capture happens on cpu_req_valid && cpu_req_ready. req can assert at the earliest in the next cycle.
- Issue:
  - inflight = out_cnt + fifo_cnt.
  - req = pend && (inflight < MAX_OUT).
  - Bus fields are driven from the request register.
  - Once req is high it stays high, with fields stable, until addr_ok. This holds through cancel; inflight cannot rise while req is high.
- Acceptance: req && addr_ok clears pend (unless refilled the same cycle) and increments out_cnt.
- Return: data_ok decrements out_cnt.
  - If discard_cnt != 0, the response is dropped and discard_cnt decrements.
  - Otherwise rdata is pushed to the response FIFO (depth MAX_OUT).
  - Simultaneous addr_ok and data_ok: both counter updates apply.
- Response:
  - cpu_resp_valid = fifo_cnt != 0. It is registered, so data_ok in cycle N gives cpu_resp_valid in N+1 at the earliest.
  - The FIFO pops on cpu_resp_valid && cpu_resp_ready.
  - Push and pop in the same cycle keep the count unchanged.
  - Pointers wrap modulo MAX_OUT.
  - The credit rule makes overflow impossible; overflow is an assertion failure.
- Cancel, in the cycle it is high:
  - The response FIFO is flushed (fifo_cnt=0) and cpu_resp_valid is 0 next cycle.
  - cpu_req_valid is ignored.
  - A pend entry with req low is dropped.
  - A pend entry with req high is kept until addr_ok; its response is discarded.
  - discard_cnt is loaded with the next-state out_cnt (including any acceptance or return this cycle) plus 1 if pend is retained. A data_ok in the cancel cycle is itself discarded and is not counted.
  - New requests are accepted from the next cycle.
  - Their responses are delivered only after discard_cnt reaches 0; ordering is guaranteed by the bus's in-order returns.
  - Back-to-back cancels reload discard_cnt each time.
- Widths: counters are $clog2(MAX_OUT+1) bits. discard_cnt never exceeds MAX_OUT.

Test Plan:
1. Reset, single read: accept addr 0x1c000000 in cycle 0 -> req=1 in cycle 1; addr_ok=1 in cycle 1; data_ok with rdata=0x12345678 in cycle 3 -> cpu_resp_valid=1 with 0x12345678 in cycle 4.
2. Back-pressure (MAX_OUT=2): cpu_resp_ready=0, three reads issued -> only two accepted on the bus; third req held high with no addr_ok until one response is popped; responses arrive in order.
3. Write: wr=1, size=2, wstrb=0xF, addr 0x100, wdata 0xDEADBEEF -> bus fields stable while addr_ok is delayed 3 cycles; data_ok -> one cpu_resp_valid pulse.
4. Cancel: two reads outstanding plus one pend with req high; cancel pulse; then new read 0x200 -> first three data_ok are dropped (discard_cnt 3->0); only 0x200's data is delivered.
5. Cancel coincident with data_ok and a cpu_req_valid -> that response is dropped; the request is not accepted (cpu_req_ready=0); fifo_cnt=0 next cycle.
6. Async reset mid-transfer: resetn low while req=1 -> req, cpu_resp_valid and all counters are 0 immediately, without a clock edge.

Source files
------------

// File: rtl/sram_like_bridge_if.sv
// Stage-side request/response and SRAM-like bus signals of one bridge.
// slave: bridge view; master: stage plus bus-side view.
interface sram_like_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                cpu_req_valid;
  logic                cpu_req_ready;
  logic                cpu_req_wr;
  logic [1:0]          cpu_req_size;
  logic [DATA_W/8-1:0] cpu_req_wstrb;
  logic [ADDR_W-1:0]   cpu_req_addr;
  logic [DATA_W-1:0]   cpu_req_wdata;
  logic                cpu_resp_valid;
  logic                cpu_resp_ready;
  logic [DATA_W-1:0]   cpu_resp_rdata;
  logic                req;
  logic                wr;
  logic [1:0]          size;
  logic [DATA_W/8-1:0] wstrb;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic                addr_ok;
  logic                data_ok;
  logic [DATA_W-1:0]   rdata;

  modport slave (
    input  cpu_req_valid, cpu_req_wr, cpu_req_size,
    input  cpu_req_wstrb, cpu_req_addr, cpu_req_wdata,
    output cpu_req_ready,
    output cpu_resp_valid, cpu_resp_rdata,
    input  cpu_resp_ready,
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport master (
    output cpu_req_valid, cpu_req_wr, cpu_req_size,
    output cpu_req_wstrb, cpu_req_addr, cpu_req_wdata,
    input  cpu_req_ready,
    input  cpu_resp_valid, cpu_resp_rdata,
    output cpu_resp_ready,
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_bridge.sv
// Stage handshake to split-transaction SRAM-like bus bridge, in-order.
// Ports: clk, resetn (async low), cancel (flush), io (slave modport).
module sram_like_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cancel,
  sram_like_bridge_if.slave io
);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int SW = DATA_W / 8;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [PW-1:0] ptr_t;

  localparam cnt_t MAX_C = cnt_t'(MAX_OUT);
  localparam ptr_t LAST  = ptr_t'(MAX_OUT - 1);

  logic              pend;
  logic              r_wr;
  logic [1:0]        r_size;
  logic [SW-1:0]     r_wstrb;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  cnt_t out_cnt;
  cnt_t fifo_cnt;
  cnt_t discard_cnt;
  ptr_t wptr;
  ptr_t rptr;
  logic [DATA_W-1:0] mem [MAX_OUT];

  logic [CW:0] inflight;
  logic        acc_bus;
  logic        take;
  logic        drop;
  logic        push;
  logic        pop;
  logic        keep_pend;
  cnt_t        out_nxt;

  function automatic ptr_t inc(input ptr_t p);
    return (p == LAST) ? '0 : p + ptr_t'(1);
  endfunction

  // Credit: a request only issues if its response has a FIFO slot.
  assign inflight  = {1'b0, out_cnt} + {1'b0, fifo_cnt};
  assign io.req    = pend && (inflight < {1'b0, MAX_C});
  assign acc_bus   = io.req && io.addr_ok;

  assign io.cpu_req_ready = !cancel && (!pend || acc_bus);
  assign take = io.cpu_req_valid && io.cpu_req_ready;

  assign out_nxt   = out_cnt + cnt_t'(acc_bus) - cnt_t'(io.data_ok);
  assign drop      = io.data_ok && (discard_cnt != '0);
  assign push      = io.data_ok && !drop && !cancel;
  assign pop       = io.cpu_resp_valid && io.cpu_resp_ready;
  assign keep_pend = pend && io.req && !io.addr_ok;

  assign io.cpu_resp_valid = (fifo_cnt != '0);
  assign io.cpu_resp_rdata = mem[rptr];

  assign io.wr    = r_wr;
  assign io.size  = r_size;
  assign io.wstrb = r_wstrb;
  assign io.addr  = r_addr;
  assign io.wdata = r_wdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend    <= 1'b0;
      r_wr    <= 1'b0;
      r_size  <= '0;
      r_wstrb <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (take) begin
      pend    <= 1'b1;
      r_wr    <= io.cpu_req_wr;
      r_size  <= io.cpu_req_size;
      r_wstrb <= io.cpu_req_wstrb;
      r_addr  <= io.cpu_req_addr;
      r_wdata <= io.cpu_req_wdata;
    end else if (acc_bus || (cancel && !io.req)) begin
      // A request already on the bus must complete its handshake.
      pend    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_cnt     <= '0;
      discard_cnt <= '0;
    end else begin
      out_cnt <= out_nxt;
      // Everything still owed by the bus after this cycle is stale.
      if (cancel)
        discard_cnt <= out_nxt + cnt_t'(keep_pend);
      else if (drop)
        discard_cnt <= discard_cnt - cnt_t'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fifo_cnt <= '0;
      wptr     <= '0;
      rptr     <= '0;
      for (int i = 0; i < MAX_OUT; i++)
        mem[i] <= '0;
    end else if (cancel) begin
      fifo_cnt <= '0;
      wptr     <= '0;
      rptr     <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= io.rdata;
        wptr      <= inc(wptr);
      end
      if (pop)
        rptr <= inc(rptr);
      fifo_cnt <= fifo_cnt + cnt_t'(push) - cnt_t'(pop);
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!resetn)
    !(push && !pop && fifo_cnt == MAX_C)
  );
endmodule

// File: tb/tb_sram_like_bridge.sv
// Self-checking bench for sram_like_bridge: directed scenarios
// plus randomized traffic against an epoch-based response model.
module tb_sram_like_bridge;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 3;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic cancel = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_like_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) sb ();

  sram_like_bridge #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO)
  ) dut (
    .clk(clk), .resetn(resetn), .cancel(cancel), .io(sb.slave)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle();
    cancel = 1'b0;
    sb.cpu_req_valid = 1'b0;
    sb.cpu_req_wr = 1'b0;
    sb.cpu_req_size = 2'd0;
    sb.cpu_req_wstrb = '0;
    sb.cpu_req_addr = '0;
    sb.cpu_req_wdata = '0;
    sb.cpu_resp_ready = 1'b0;
    sb.addr_ok = 1'b0;
    sb.data_ok = 1'b0;
    sb.rdata = '0;
  endtask

  task automatic do_reset();
    idle();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    sb.cpu_req_valid = 1'b1;
    sb.cpu_req_wr = 1'b0;
    sb.cpu_req_size = 2'd2;
    sb.cpu_req_wstrb = '0;
    sb.cpu_req_addr = a;
    sb.cpu_req_wdata = '0;
  endtask

  function automatic logic [DW-1:0] rd_of(input logic [AW-1:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  task automatic test_reset();
    logic [107:0] got;
    logic [107:0] want;
    idle();
    #2 resetn = 1'b0;
    #1;
    got = {sb.req, sb.cpu_resp_valid, sb.cpu_req_ready, sb.wr,
           sb.size, sb.wstrb, sb.addr, sb.wdata, sb.cpu_resp_rdata};
    want = {1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 32'd0, 32'd0, 32'd0};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL reset_outputs got %h want %h", got, want);
    end
    checks++;
    if ({dut.pend, dut.out_cnt, dut.fifo_cnt, dut.discard_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_state got pend=%b out=%0d fifo=%0d disc=%0d want 0",
               dut.pend, dut.out_cnt, dut.fifo_cnt, dut.discard_cnt);
    end
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    mid();
    checks++;
    if ({sb.req, sb.cpu_resp_valid, sb.cpu_req_ready} !== 3'b001) begin
      errors++;
      $display("FAIL reset_release got %b want 001",
               {sb.req, sb.cpu_resp_valid, sb.cpu_req_ready});
    end
  endtask

  task automatic test_single_read();
    do_reset();
    rd(32'h1c000000);
    mid();
    checks++;
    if ({sb.cpu_req_ready, sb.req} !== 2'b10) begin
      errors++;
      $display("FAIL sr_accept got %b want 10", {sb.cpu_req_ready, sb.req});
    end
    cyc();
    sb.cpu_req_valid = 1'b0;
    sb.addr_ok = 1'b1;
    mid();
    checks++;
    if ({sb.req, sb.addr} !== {1'b1, 32'h1c000000}) begin
      errors++;
      $display("FAIL sr_req got %b/%h want 1/1c000000", sb.req, sb.addr);
    end
    cyc();
    sb.addr_ok = 1'b0;
    mid();
    checks++;
    if (sb.req !== 1'b0) begin
      errors++;
      $display("FAIL sr_req_drop got %b want 0", sb.req);
    end
    cyc();
    sb.data_ok = 1'b1;
    sb.rdata = 32'h12345678;
    mid();
    checks++;
    if (sb.cpu_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL sr_resp_early got %b want 0", sb.cpu_resp_valid);
    end
    cyc();
    sb.data_ok = 1'b0;
    sb.rdata = '0;
    sb.cpu_resp_ready = 1'b1;
    mid();
    checks++;
    if ({sb.cpu_resp_valid, sb.cpu_resp_rdata} !== {1'b1, 32'h12345678}) begin
      errors++;
      $display("FAIL sr_resp got %b/%h want 1/12345678",
               sb.cpu_resp_valid, sb.cpu_resp_rdata);
    end
    cyc();
    mid();
    checks++;
    if (sb.cpu_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL sr_resp_pop got %b want 0", sb.cpu_resp_valid);
    end
  endtask

  task automatic test_back_pressure();
    logic [AW-1:0] a;
    do_reset();
    sb.addr_ok = 1'b1;
    for (int i = 0; i <= MO; i++) begin
      rd(32'h1000 + 32'(i) * 32'h10);
      mid();
      if (i > 0) begin
        a = 32'h1000 + 32'(i - 1) * 32'h10;
        checks++;
        if ({sb.req, sb.addr, sb.cpu_req_ready} !== {1'b1, a, 1'b1}) begin
          errors++;
          $display("FAIL bp_issue got %b/%h/%b want 1/%h/1",
                   sb.req, sb.addr, sb.cpu_req_ready, a);
        end
      end
      cyc();
    end
    sb.cpu_req_valid = 1'b0;
    for (int j = 0; j < MO; j++) begin
      sb.data_ok = 1'b1;
      sb.rdata = 32'hB000 + 32'(j);
      mid();
      checks++;
      if ({sb.req, sb.cpu_req_ready} !== 2'b00) begin
        errors++;
        $display("FAIL bp_hold got %b want 00", {sb.req, sb.cpu_req_ready});
      end
      cyc();
    end
    sb.data_ok = 1'b0;
    mid();
    checks++;
    if ({sb.req, sb.cpu_resp_valid} !== 2'b01) begin
      errors++;
      $display("FAIL bp_full got %b want 01", {sb.req, sb.cpu_resp_valid});
    end
    cyc();
    sb.cpu_resp_ready = 1'b1;
    for (int j = 0; j < MO; j++) begin
      mid();
      checks++;
      if ({sb.cpu_resp_valid, sb.cpu_resp_rdata} !== {1'b1, 32'hB000 + 32'(j)}) begin
        errors++;
        $display("FAIL bp_order got %b/%h want 1/%h",
                 sb.cpu_resp_valid, sb.cpu_resp_rdata, 32'hB000 + 32'(j));
      end
      if (j == 1) begin
        a = 32'h1000 + 32'(MO) * 32'h10;
        checks++;
        if ({sb.req, sb.addr} !== {1'b1, a}) begin
          errors++;
          $display("FAIL bp_release got %b/%h want 1/%h", sb.req, sb.addr, a);
        end
      end
      cyc();
    end
    sb.addr_ok = 1'b0;
    sb.data_ok = 1'b1;
    sb.rdata = 32'hB000 + 32'(MO);
    cyc();
    sb.data_ok = 1'b0;
    mid();
    checks++;
    if ({sb.cpu_resp_valid, sb.cpu_resp_rdata} !== {1'b1, 32'hB000 + 32'(MO)}) begin
      errors++;
      $display("FAIL bp_last got %b/%h want 1/%h",
               sb.cpu_resp_valid, sb.cpu_resp_rdata, 32'hB000 + 32'(MO));
    end
  endtask

  task automatic test_write();
    int pulses;
    logic [71:0] want;
    do_reset();
    sb.cpu_req_valid = 1'b1;
    sb.cpu_req_wr = 1'b1;
    sb.cpu_req_size = 2'd2;
    sb.cpu_req_wstrb = 4'hF;
    sb.cpu_req_addr = 32'h100;
    sb.cpu_req_wdata = 32'hDEADBEEF;
    cyc();
    rd('0);
    sb.cpu_req_valid = 1'b0;
    want = {1'b1, 1'b1, 2'd2, 4'hF, 32'h100, 32'hDEADBEEF};
    for (int k = 0; k < 4; k++) begin
      sb.addr_ok = (k == 3);
      mid();
      checks++;
      if ({sb.req, sb.wr, sb.size, sb.wstrb, sb.addr, sb.wdata} !== want) begin
        errors++;
        $display("FAIL wr_fields got %h want %h",
                 {sb.req, sb.wr, sb.size, sb.wstrb, sb.addr, sb.wdata}, want);
      end
      cyc();
    end
    sb.addr_ok = 1'b0;
    sb.data_ok = 1'b1;
    sb.cpu_resp_ready = 1'b1;
    cyc();
    sb.data_ok = 1'b0;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      mid();
      if (sb.cpu_resp_valid === 1'b1) pulses++;
      cyc();
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL wr_resp_pulse got %0d want 1", pulses);
    end
  endtask

  task automatic test_cancel();
    do_reset();
    sb.cpu_resp_ready = 1'b1;
    rd(32'h10);
    cyc();
    rd(32'h20);
    sb.addr_ok = 1'b1;
    cyc();
    rd(32'h30);
    cyc();
    rd(32'h40);
    sb.addr_ok = 1'b0;
    cancel = 1'b1;
    mid();
    checks++;
    if ({sb.req, sb.addr, sb.cpu_req_ready} !== {1'b1, 32'h30, 1'b0}) begin
      errors++;
      $display("FAIL cn_hold got %b/%h/%b want 1/30/0",
               sb.req, sb.addr, sb.cpu_req_ready);
    end
    cyc();
    cancel = 1'b0;
    rd(32'h200);
    sb.addr_ok = 1'b1;
    mid();
    checks++;
    if ({sb.req, sb.addr, sb.cpu_req_ready} !== {1'b1, 32'h30, 1'b1}) begin
      errors++;
      $display("FAIL cn_kept got %b/%h/%b want 1/30/1",
               sb.req, sb.addr, sb.cpu_req_ready);
    end
    checks++;
    if (dut.discard_cnt !== 2'd3) begin
      errors++;
      $display("FAIL cn_discard got %0d want 3", dut.discard_cnt);
    end
    cyc();
    sb.cpu_req_valid = 1'b0;
    sb.addr_ok = 1'b0;
    sb.data_ok = 1'b1;
    sb.rdata = 32'hA1;
    mid();
    checks++;
    if ({sb.req, sb.cpu_resp_valid} !== 2'b00) begin
      errors++;
      $display("FAIL cn_full got %b want 00", {sb.req, sb.cpu_resp_valid});
    end
    cyc();
    sb.addr_ok = 1'b1;
    sb.rdata = 32'hA2;
    mid();
    checks++;
    if ({sb.req, sb.addr, sb.cpu_resp_valid} !== {1'b1, 32'h200, 1'b0}) begin
      errors++;
      $display("FAIL cn_new got %b/%h/%b want 1/200/0",
               sb.req, sb.addr, sb.cpu_resp_valid);
    end
    cyc();
    sb.addr_ok = 1'b0;
    sb.rdata = 32'hA3;
    mid();
    checks++;
    if (sb.cpu_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL cn_drop3 got %b want 0", sb.cpu_resp_valid);
    end
    cyc();
    sb.rdata = 32'hD00D;
    mid();
    checks++;
    if ({sb.cpu_resp_valid, dut.discard_cnt} !== {1'b0, 2'd0}) begin
      errors++;
      $display("FAIL cn_drained got %b/%0d want 0/0",
               sb.cpu_resp_valid, dut.discard_cnt);
    end
    cyc();
    sb.data_ok = 1'b0;
    mid();
    checks++;
    if ({sb.cpu_resp_valid, sb.cpu_resp_rdata} !== {1'b1, 32'hD00D}) begin
      errors++;
      $display("FAIL cn_deliver got %b/%h want 1/0000d00d",
               sb.cpu_resp_valid, sb.cpu_resp_rdata);
    end
    cyc();
    mid();
    checks++;
    if (sb.cpu_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL cn_single got %b want 0", sb.cpu_resp_valid);
    end
  endtask

  task automatic test_cancel_data();
    do_reset();
    rd(32'h50);
    cyc();
    rd(32'h60);
    sb.addr_ok = 1'b1;
    cyc();
    sb.cpu_req_valid = 1'b0;
    cyc();
    sb.addr_ok = 1'b0;
    sb.data_ok = 1'b1;
    sb.rdata = 32'hE1;
    cyc();
    rd(32'h70);
    sb.rdata = 32'hE2;
    cancel = 1'b1;
    mid();
    checks++;
    if ({sb.cpu_resp_valid, sb.cpu_req_ready} !== 2'b10) begin
      errors++;
      $display("FAIL cd_ready got %b want 10",
               {sb.cpu_resp_valid, sb.cpu_req_ready});
    end
    cyc();
    cancel = 1'b0;
    sb.cpu_req_valid = 1'b0;
    sb.data_ok = 1'b0;
    mid();
    checks++;
    if ({sb.cpu_resp_valid, sb.req, dut.fifo_cnt, dut.discard_cnt} !== '0) begin
      errors++;
      $display("FAIL cd_flush got v=%b req=%b fifo=%0d disc=%0d want 0",
               sb.cpu_resp_valid, sb.req, dut.fifo_cnt, dut.discard_cnt);
    end
    cyc();
    sb.cpu_resp_ready = 1'b1;
    mid();
    checks++;
    if ({sb.cpu_resp_valid, sb.req} !== 2'b00) begin
      errors++;
      $display("FAIL cd_quiet got %b want 00", {sb.cpu_resp_valid, sb.req});
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    sb.addr_ok = 1'b1;
    rd(32'h80);
    cyc();
    rd(32'h90);
    cyc();
    rd(32'hA0);
    cyc();
    sb.cpu_req_valid = 1'b0;
    sb.addr_ok = 1'b0;
    sb.data_ok = 1'b1;
    sb.rdata = 32'h77;
    cyc();
    sb.data_ok = 1'b0;
    mid();
    checks++;
    if ({sb.req, sb.cpu_resp_valid} !== 2'b11) begin
      errors++;
      $display("FAIL ar_setup got %b want 11", {sb.req, sb.cpu_resp_valid});
    end
    #1 resetn = 1'b0;
    #1;
    checks++;
    if ({sb.req, sb.cpu_resp_valid, sb.cpu_req_ready} !== 3'b001) begin
      errors++;
      $display("FAIL ar_outputs got %b want 001",
               {sb.req, sb.cpu_resp_valid, sb.cpu_req_ready});
    end
    checks++;
    if ({dut.pend, dut.out_cnt, dut.fifo_cnt, dut.discard_cnt} !== '0) begin
      errors++;
      $display("FAIL ar_state got pend=%b out=%0d fifo=%0d disc=%0d want 0",
               dut.pend, dut.out_cnt, dut.fifo_cnt, dut.discard_cnt);
    end
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  typedef struct packed {
    logic          wr;
    logic [1:0]    size;
    logic [SW-1:0] wstrb;
    logic [DW-1:0] wdata;
    int unsigned   ep;
  } rq_t;

  typedef struct {
    logic          wr;
    logic [DW-1:0] d;
  } rsp_t;

  task automatic test_random();
    rq_t info [logic [AW-1:0]];
    rq_t r;
    rsp_t e;
    logic [AW-1:0] bus_q [$];
    rsp_t exp_q [$];
    logic [AW-1:0] a;
    int unsigned epoch;
    int unsigned serial;
    int delivered;
    logic hold;
    logic [71:0] hold_vec;
    logic [71:0] now_vec;
    epoch = 0;
    serial = 1;
    delivered = 0;
    hold = 1'b0;
    hold_vec = '0;
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      cancel = ($urandom_range(0, 99) < 4);
      sb.cpu_req_valid = $urandom_range(0, 1) == 1;
      sb.cpu_req_wr = $urandom_range(0, 1) == 1;
      sb.cpu_req_size = 2'($urandom_range(0, 2));
      sb.cpu_req_wstrb = 4'($urandom);
      sb.cpu_req_addr = (32'(serial) << 4) | 32'($urandom_range(0, 15));
      sb.cpu_req_wdata = $urandom;
      serial++;
      sb.cpu_resp_ready = $urandom_range(0, 3) != 0;
      sb.addr_ok = $urandom_range(0, 2) == 0;
      sb.data_ok = (bus_q.size() != 0) && ($urandom_range(0, 2) != 0);
      sb.rdata = sb.data_ok ? rd_of(bus_q[0]) : $urandom;
      mid();
      checks++;
      if (sb.cpu_resp_valid !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL rnd_valid got %b want %0d cycle %0d",
                 sb.cpu_resp_valid, exp_q.size() != 0, n);
      end
      if (cancel) begin
        checks++;
        if (sb.cpu_req_ready !== 1'b0) begin
          errors++;
          $display("FAIL rnd_cancel_ready got %b want 0", sb.cpu_req_ready);
        end
      end
      now_vec = {sb.req, sb.wr, sb.size, sb.wstrb, sb.addr, sb.wdata};
      if (hold) begin
        checks++;
        if (now_vec !== hold_vec) begin
          errors++;
          $display("FAIL rnd_stable got %h want %h", now_vec, hold_vec);
        end
      end
      if (sb.req === 1'b1) begin
        checks++;
        if (!info.exists(sb.addr)) begin
          errors++;
          $display("FAIL rnd_addr got %h want a captured address", sb.addr);
        end else begin
          r = info[sb.addr];
          if ({sb.wr, sb.size, sb.wstrb, sb.wdata} !==
              {r.wr, r.size, r.wstrb, r.wdata}) begin
            errors++;
            $display("FAIL rnd_fields got %h want %h",
                     {sb.wr, sb.size, sb.wstrb, sb.wdata},
                     {r.wr, r.size, r.wstrb, r.wdata});
          end
        end
        checks++;
        if (bus_q.size() + exp_q.size() >= MO) begin
          errors++;
          $display("FAIL rnd_credit got %0d in flight want < %0d",
                   bus_q.size() + exp_q.size(), MO);
        end
      end
      if (sb.cpu_resp_valid && sb.cpu_resp_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        delivered++;
        if (!e.wr) begin
          checks++;
          if (sb.cpu_resp_rdata !== e.d) begin
            errors++;
            $display("FAIL rnd_rdata got %h want %h", sb.cpu_resp_rdata, e.d);
          end
        end
      end
      if (sb.data_ok) begin
        a = bus_q.pop_front();
        if (!cancel && info[a].ep == epoch) begin
          e.wr = info[a].wr;
          e.d = rd_of(a);
          exp_q.push_back(e);
        end
      end
      if (cancel) begin
        exp_q.delete();
        epoch++;
      end
      if (sb.cpu_req_valid && sb.cpu_req_ready) begin
        r.wr = sb.cpu_req_wr;
        r.size = sb.cpu_req_size;
        r.wstrb = sb.cpu_req_wstrb;
        r.wdata = sb.cpu_req_wdata;
        r.ep = epoch;
        info[sb.cpu_req_addr] = r;
      end
      if (sb.req && sb.addr_ok) bus_q.push_back(sb.addr);
      hold = sb.req && !sb.addr_ok;
      hold_vec = now_vec;
      cyc();
    end
    idle();
    checks++;
    if (delivered < 100) begin
      errors++;
      $display("FAIL rnd_progress got %0d responses want >= 100", delivered);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_single_read();
    test_back_pressure();
    test_write();
    test_cancel();
    test_cancel_data();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
